bcd_multi_counter: RTL and testbench

// - Parametrised N-digit cascaded BCD stopwatch counter; successor to the 2-digit seconds counter.
// - Sits between the stopwatch control FSM (one-hot state) and the 7-seg decoders.
// - Counts up or down on the 1 Hz sec_pulse, with per-digit modulus (mod-10 or mod-6 for tens-of-seconds/minutes).

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_multi_counter.sv | 109 ++++++++++
 tb/tb_bcd_multi_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: one-hot control states, BCD digit type and digit limits.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b100,
    ST_CLEAR   = 3'b010,
    ST_RUNNING = 3'b001
  } state_t;

  function automatic bcd_t digit_max(input logic mod6);
    return mod6 ? bcd_t'(5) : bcd_t'(9);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register (mod-10 or mod-6) with carry/borrow ripple for the cascaded counter.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic cin,
  input  logic bin,
  input  logic dir,
  input  logic clr,
  input  logic mod6,
  output bcd_t value,
  output logic cout,
  output logic bout
);

  bcd_t max_val;
  logic up_step;
  logic dn_step;

  assign max_val = digit_max(mod6);
  assign up_step = cin & ~dir;
  assign dn_step = bin & dir;

  // A digit above its max (only after a glitch) is treated as full so it wraps and carries.
  assign cout = up_step & (value >= max_val);
  assign bout = dn_step & (value == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (up_step) begin
      value <= (value >= max_val) ? '0 : value + bcd_t'(1);
    end else if (dn_step) begin
      value <= ((value == '0) || (value > max_val)) ? max_val : value - bcd_t'(1);
    end
  end

endmodule

// File: rtl/bcd_multi_counter.sv
// N-digit cascaded BCD stopwatch counter (up/down, per-digit modulus, wrap or saturate).
// Optional lap-hold display freeze is built when the LAP_HOLD_EN macro is defined.
module bcd_multi_counter
  import stopwatch_pkg::*;
#(
  parameter int       NUM_DIGITS = 4,
  parameter logic [7:0] MOD6_MASK = 8'b0000_1010,
  parameter bit       WRAP_UP    = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [2:0]              state,
  input  logic                    sec_pulse,
  input  logic                    down,
`ifdef LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    enable,
  output logic                    rollover,
  output logic                    at_zero
);

  localparam int W = BCD_W * NUM_DIGITS;

  logic                  is_clear;
  logic                  is_running;
  logic                  tick_run;
  logic                  all_max;
  logic                  up_go;
  logic                  dn_go;
  logic [W-1:0]          live;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS:0]   borrow;
  logic [NUM_DIGITS-1:0] dig_max;
  logic [NUM_DIGITS-1:0] dig_zero;
  logic                  unused_borrow;

  // Anything that is not exactly CLEAR or RUNNING behaves as IDLE.
  assign is_clear   = (state == ST_CLEAR);
  assign is_running = (state == ST_RUNNING);
  assign tick_run   = is_running & sec_pulse;
  assign enable     = ~is_clear;

  assign all_max = &dig_max;
  assign at_zero = &dig_zero;

  // Saturating builds block the step at all-max; countdown stops at zero.
  assign up_go     = tick_run & ~down & (WRAP_UP | ~all_max);
  assign dn_go     = tick_run & down & ~at_zero;
  assign carry[0]  = up_go;
  assign borrow[0] = dn_go;

  assign unused_borrow = borrow[NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .nrst  (nrst),
      .cin   (carry[g]),
      .bin   (borrow[g]),
      .dir   (down),
      .clr   (is_clear),
      .mod6  (MOD6_MASK[g]),
      .value (live[g*BCD_W +: BCD_W]),
      .cout  (carry[g+1]),
      .bout  (borrow[g+1])
    );

    assign dig_max[g]  = (live[g*BCD_W +: BCD_W] == digit_max(MOD6_MASK[g]));
    assign dig_zero[g] = (live[g*BCD_W +: BCD_W] == '0);
  end

  // A carry out of the top digit only exists on an all-max wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rollover <= 1'b0;
    end else begin
      rollover <= carry[NUM_DIGITS];
    end
  end

`ifdef LAP_HOLD_EN
  logic         lap_hold;
  logic [W-1:0] lap_reg;

  // Lap pulses alternate between freezing the display and releasing it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lap_hold <= 1'b0;
      lap_reg  <= '0;
    end else if (is_clear) begin
      lap_hold <= 1'b0;
    end else if (lap) begin
      if (!lap_hold) begin
        lap_reg  <= live;
        lap_hold <= 1'b1;
      end else begin
        lap_hold <= 1'b0;
      end
    end
  end

  assign bcd_o = lap_hold ? lap_reg : live;
`else
  assign bcd_o = live;
`endif

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Bench for bcd_multi_counter: wrapping and saturating MM:SS instances against a seconds-based model.
module tb_bcd_multi_counter;
  import stopwatch_pkg::*;

  localparam logic [2:0] S_IDLE  = 3'b100;
  localparam logic [2:0] S_CLEAR = 3'b010;
  localparam logic [2:0] S_RUN   = 3'b001;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [2:0]  state = S_IDLE;
  logic        sec_pulse = 1'b0;
  logic        down = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] bcd_o, bcd_sat;
  logic        enable, en_sat, rollover, roll_sat, at_zero, zero_sat;

  always #5 clk = ~clk;

  bcd_multi_counter #(.NUM_DIGITS(4), .MOD6_MASK(8'b0000_1010), .WRAP_UP(1'b1)) dut (
    .clk(clk), .nrst(nrst), .state(state), .sec_pulse(sec_pulse), .down(down),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .bcd_o(bcd_o), .enable(enable), .rollover(rollover), .at_zero(at_zero)
  );

  bcd_multi_counter #(.NUM_DIGITS(4), .MOD6_MASK(8'b0000_1010), .WRAP_UP(1'b0)) dut_sat (
    .clk(clk), .nrst(nrst), .state(state), .sec_pulse(sec_pulse), .down(down),
`ifdef LAP_HOLD_EN
    .lap(1'b0),
`endif
    .bcd_o(bcd_sat), .enable(en_sat), .rollover(roll_sat), .at_zero(zero_sat)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] bcd_sat;
    logic        roll;
    logic        roll_sat;
    logic        zero;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   sec_m = 0;
  int   sec_s = 0;
  int   lap_m = 0;
  bit   lap_hold_m = 1'b0;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Drive one clock of stimulus, queue the model's prediction, and land #1 after the edge.
  task automatic cycle(input logic [2:0] st, input logic tk, input logic dn, input logic lp);
    exp_t e;
    bit   clr;
    bit   run;
    state = st; sec_pulse = tk; down = dn; lap = lp;
    clr = (st == S_CLEAR);
    run = (st == S_RUN);
    e.roll = 1'b0;
    e.roll_sat = 1'b0;
    if (clr) begin
      lap_hold_m = 1'b0;
    end else if (lp) begin
      if (!lap_hold_m) begin
        lap_m = sec_m;
        lap_hold_m = 1'b1;
      end else begin
        lap_hold_m = 1'b0;
      end
    end
    if (clr) begin
      sec_m = 0;
      sec_s = 0;
    end else if (run && tk) begin
      if (!dn) begin
        if (sec_m == 3599) begin
          sec_m = 0;
          e.roll = 1'b1;
        end else begin
          sec_m++;
        end
        if (sec_s < 3599) sec_s++;
      end else begin
        if (sec_m > 0) sec_m--;
        if (sec_s > 0) sec_s--;
      end
    end
    e.bcd     = lap_hold_m ? to_bcd(lap_m) : to_bcd(sec_m);
    e.bcd_sat = to_bcd(sec_s);
    e.zero    = (sec_m == 0);
    e.en      = !clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    sec_pulse = 1'b0;
    lap = 1'b0;
  endtask

  task automatic run_ticks(input int n, input logic dn);
    exp_t e;
    repeat (n) begin
      cycle(S_RUN, 1'b1, dn, 1'b0);
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    #2;
    total++; if (bcd_o !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h want=%h", bcd_o, 16'h0000); end
    total++; if (at_zero !== 1'b1) begin bad++; $display("FAIL reset_at_zero got=%b want=1", at_zero); end
    total++; if (rollover !== 1'b0) begin bad++; $display("FAIL reset_rollover got=%b want=0", rollover); end
    nrst = 1'b1;
    @(posedge clk); #1;
    run_ticks(6, 1'b0);
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL pre_reset_count got=%h want=%h", bcd_o, e.bcd); end
    #3;
    nrst = 1'b0;
    sec_m = 0; sec_s = 0; lap_hold_m = 1'b0;
    #1;
    total++; if (bcd_o !== 16'h0000) begin bad++; $display("FAIL midcount_reset_bcd got=%h want=%h", bcd_o, 16'h0000); end
    total++; if (at_zero !== 1'b1) begin bad++; $display("FAIL midcount_reset_at_zero got=%b want=1", at_zero); end
    #1;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    exp_t e;
    run_ticks(754, 1'b0);
    cycle(S_IDLE, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL count_1234 got=%h want=%h", bcd_o, e.bcd); end
    cycle(S_CLEAR, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL clear_tick_bcd got=%h want=%h", bcd_o, e.bcd); end
    total++; if (enable !== e.en) begin bad++; $display("FAIL clear_enable got=%b want=%b", enable, e.en); end
  endtask

  task automatic test_up_carry();
    exp_t e;
    run_ticks(59, 1'b0);
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL carry_0059 got=%h want=%h", bcd_o, e.bcd); end
    run_ticks(539, 1'b0);
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL carry_0959 got=%h want=%h", bcd_o, e.bcd); end
    total++; if (bcd_sat !== e.bcd_sat) begin bad++; $display("FAIL carry_0959_sat got=%h want=%h", bcd_sat, e.bcd_sat); end
  endtask

  task automatic test_idle_hold();
    exp_t e;
    repeat (3) begin
      cycle(S_IDLE, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL idle_hold got=%h want=%h", bcd_o, e.bcd); end
    total++; if (enable !== e.en) begin bad++; $display("FAIL idle_enable got=%b want=%b", enable, e.en); end
  endtask

  task automatic test_wrap();
    exp_t e;
    run_ticks(2998, 1'b0);
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL reach_5959 got=%h want=%h", bcd_o, e.bcd); end
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL wrap_bcd got=%h want=%h", bcd_o, e.bcd); end
    total++; if (rollover !== e.roll) begin bad++; $display("FAIL wrap_rollover got=%b want=%b", rollover, e.roll); end
    total++; if (at_zero !== e.zero) begin bad++; $display("FAIL wrap_at_zero got=%b want=%b", at_zero, e.zero); end
    total++; if (bcd_sat !== e.bcd_sat) begin bad++; $display("FAIL sat_bcd got=%h want=%h", bcd_sat, e.bcd_sat); end
    total++; if (roll_sat !== e.roll_sat) begin bad++; $display("FAIL sat_rollover got=%b want=%b", roll_sat, e.roll_sat); end
    cycle(S_IDLE, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (rollover !== e.roll) begin bad++; $display("FAIL rollover_width got=%b want=%b", rollover, e.roll); end
  endtask

  task automatic test_down();
    exp_t e;
    cycle(S_CLEAR, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    run_ticks(60, 1'b0);
    cycle(S_RUN, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL borrow_0100 got=%h want=%h", bcd_o, e.bcd); end
    run_ticks(58, 1'b1);
    cycle(S_RUN, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL down_to_zero got=%h want=%h", bcd_o, e.bcd); end
    total++; if (at_zero !== e.zero) begin bad++; $display("FAIL down_at_zero got=%b want=%b", at_zero, e.zero); end
    run_ticks(1, 1'b1);
    cycle(S_RUN, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL down_hold got=%h want=%h", bcd_o, e.bcd); end
    total++; if (rollover !== e.roll) begin bad++; $display("FAIL down_no_roll got=%b want=%b", rollover, e.roll); end
  endtask

  task automatic test_illegal();
    exp_t e;
    run_ticks(5, 1'b0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL illegal_hold got=%h want=%h", bcd_o, e.bcd); end
    total++; if (enable !== e.en) begin bad++; $display("FAIL illegal_enable got=%b want=%b", enable, e.en); end
    cycle(S_CLEAR, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL clear_wins got=%h want=%h", bcd_o, e.bcd); end
  endtask

`ifdef LAP_HOLD_EN
  task automatic test_lap();
    exp_t e;
    run_ticks(10, 1'b0);
    cycle(S_IDLE, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL lap_snap got=%h want=%h", bcd_o, e.bcd); end
    run_ticks(4, 1'b0);
    cycle(S_RUN, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL lap_frozen got=%h want=%h", bcd_o, e.bcd); end
    cycle(S_IDLE, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++; if (bcd_o !== e.bcd) begin bad++; $display("FAIL lap_release got=%h want=%h", bcd_o, e.bcd); end
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_up_carry();
    test_idle_hold();
    test_wrap();
    test_down();
    test_illegal();
`ifdef LAP_HOLD_EN
    test_lap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
